// File: rtl/md_packet_builder.sv
// md_packet_builder: builds one 50-byte UDP/IPv4/Ethernet market-data frame per request and streams it as 8-bit AXI-Stream
module md_packet_builder #(
  parameter logic [47:0] DST_MAC  = 48'h01005E000001,
  parameter logic [47:0] SRC_MAC  = 48'h020000000001,
  parameter logic [31:0] SRC_IP   = 32'hC0A80001,
  parameter logic [31:0] DST_IP   = 32'hEF000001,
  parameter logic [15:0] SRC_PORT = 16'h1388,
  parameter logic [15:0] DST_PORT = 16'h1389,
  parameter logic [7:0]  TTL      = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic [31:0] s_req_symbol,
  input  logic [31:0] s_req_price,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] pkt_id
);
  typedef enum logic [1:0] {IDLE, CSUM, SEND} state_t;
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [31:0] sym_q, sym_d, price_q, price_d;
  logic [15:0] csum_q, csum_d, pkt_id_q, pkt_id_d;
  logic tvalid_q, tvalid_d;
  logic beat, last, accept;
  logic [19:0] sum0;
  logic [16:0] sum1, sum2;
  logic [399:0] frame, frame_sh;
  always_comb begin
    beat     = tvalid_q && m_axis_tready;
    last     = idx_q == 6'd49;
    accept   = state_q == IDLE && s_req_valid;
    sum0     = 20'h04500 + 20'h00024 + {4'h0, pkt_id_q} + 20'h04000 + {4'h0, TTL, 8'h11}
             + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]} + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
    sum1     = {1'b0, sum0[15:0]} + {13'h0, sum0[19:16]};
    sum2     = {1'b0, sum1[15:0]} + {16'h0, sum1[16]};
    state_d  = state_q == IDLE ? (s_req_valid ? CSUM : IDLE)
             : state_q == CSUM ? SEND
             : (beat && last ? IDLE : SEND);
    sym_d    = accept ? s_req_symbol : sym_q;
    price_d  = accept ? s_req_price : price_q;
    csum_d   = state_q == CSUM ? ~sum2[15:0] : csum_q;
    idx_d    = state_q == CSUM ? 6'd0 : beat ? idx_q + 6'd1 : idx_q;
    tvalid_d = state_q == SEND && !(beat && last);
    pkt_id_d = beat && last ? pkt_id_q + 16'd1 : pkt_id_q;
    frame    = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, 16'h0024, pkt_id_q, 16'h4000, TTL, 8'h11,
                csum_q, SRC_IP, DST_IP, SRC_PORT, DST_PORT, 16'h0010, 16'h0000, sym_q, price_q};
    frame_sh = frame << {idx_q, 3'b000};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sym_q    <= '0;
      price_q  <= '0;
      csum_q   <= '0;
      pkt_id_q <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sym_q    <= sym_d;
      price_q  <= price_d;
      csum_q   <= csum_d;
      pkt_id_q <= pkt_id_d;
      tvalid_q <= tvalid_d;
    end
  end
  assign s_req_ready   = state_q == IDLE;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tvalid_q ? frame_sh[399:392] : 8'h00;
  assign m_axis_tlast  = tvalid_q && last;
  assign pkt_id        = pkt_id_q;
endmodule
